// File: rtl/btb_predictor_n_if.sv
// Fetch-side lookup and branch-resolution update bus for btb_predictor_n.
interface btb_predictor_n_if #(
  parameter int ADDR_W  = 16,
  parameter int ENTRIES = 8,
  parameter int FETCH_W = 2
);
  localparam int OCC_W = $clog2(ENTRIES) + 1;

  logic                      stall;
  logic [ADDR_W-1:0]         lookup_pc;
  logic [FETCH_W-1:0]        hit;
  logic [FETCH_W-1:0]        taken;
  logic [FETCH_W*ADDR_W-1:0] target;
  logic [FETCH_W-1:0]        slot_valid;
  logic [ADDR_W-1:0]         next_pc;
  logic                      update_valid;
  logic [ADDR_W-1:0]         update_addr;
  logic                      update_taken;
  logic [ADDR_W-1:0]         update_target;
  logic [OCC_W-1:0]          occupancy;

  modport master (
    output stall, lookup_pc, update_valid, update_addr, update_taken, update_target,
    input  hit, taken, target, slot_valid, next_pc, occupancy
  );

  modport slave (
    input  stall, lookup_pc, update_valid, update_addr, update_taken, update_target,
    output hit, taken, target, slot_valid, next_pc, occupancy
  );
endinterface

// File: rtl/btb_predictor_n.sv
// Branch target buffer for an N-wide fetch stage: combinational multi-slot
// lookup and next-PC prediction, clocked updates with saturating counters
// and true-LRU replacement.
module btb_predictor_n #(
  parameter int ADDR_W      = 16,
  parameter int ENTRIES     = 8,
  parameter int FETCH_W     = 2,
  parameter int INSTR_BYTES = 2,
  parameter int CTR_W       = 2
) (
  input logic               clk,
  input logic               rst,
  btb_predictor_n_if.slave  bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int OCC_W = IDX_W + 1;
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);

  logic              valid [ENTRIES];
  logic [ADDR_W-1:0] tag   [ENTRIES];
  logic [ADDR_W-1:0] tgt   [ENTRIES];
  logic [CTR_W-1:0]  ctr   [ENTRIES];
  logic [IDX_W-1:0]  age   [ENTRIES];
  logic [OCC_W-1:0]  occ;

  logic [FETCH_W-1:0]        hit_v;
  logic [FETCH_W-1:0]        taken_v;
  logic [FETCH_W*ADDR_W-1:0] target_v;
  logic [IDX_W-1:0]          slot_idx [FETCH_W];
  logic [FETCH_W-1:0]        slot_valid_v;
  logic [ADDR_W-1:0]         next_pc_v;
  logic                      pred_found;

  logic              upd_match;
  logic [IDX_W-1:0]  match_idx;
  logic              any_invalid;
  logic [IDX_W-1:0]  alloc_idx;
  logic [IDX_W-1:0]  write_idx;
  logic              lk_hit_any;
  logic [IDX_W-1:0]  lk_idx;
  logic              touch_en;
  logic [IDX_W-1:0]  touch_idx;

  // Per-slot tag match against the pre-edge table contents.
  always_comb begin
    hit_v    = '0;
    taken_v  = '0;
    target_v = '0;
    for (int unsigned s = 0; s < FETCH_W; s++) begin
      slot_idx[s] = '0;
      for (int unsigned e = 0; e < ENTRIES; e++) begin
        if (valid[e] && tag[e] == bus.lookup_pc + ADDR_W'(s * INSTR_BYTES)) begin
          hit_v[s]                     = 1'b1;
          taken_v[s]                   = ctr[e][CTR_W-1];
          target_v[s*ADDR_W +: ADDR_W] = tgt[e];
          slot_idx[s]                  = IDX_W'(e);
        end
      end
    end
  end

  // Oldest predicted-taken slot redirects fetch and squashes later slots.
  always_comb begin
    pred_found   = 1'b0;
    slot_valid_v = '1;
    next_pc_v    = bus.lookup_pc + ADDR_W'(FETCH_W * INSTR_BYTES);
    for (int unsigned s = 0; s < FETCH_W; s++) begin
      if (pred_found) begin
        slot_valid_v[s] = 1'b0;
      end else if (taken_v[s]) begin
        pred_found = 1'b1;
        next_pc_v  = target_v[s*ADDR_W +: ADDR_W];
      end
    end
  end

  // Update victim selection and the single per-cycle LRU touch.
  always_comb begin
    upd_match = 1'b0;
    match_idx = '0;
    for (int unsigned e = 0; e < ENTRIES; e++) begin
      if (valid[e] && tag[e] == bus.update_addr) begin
        upd_match = 1'b1;
        match_idx = IDX_W'(e);
      end
    end
    any_invalid = 1'b0;
    alloc_idx   = '0;
    for (int unsigned e = 0; e < ENTRIES; e++) begin
      if (!valid[e] && !any_invalid) begin
        any_invalid = 1'b1;
        alloc_idx   = IDX_W'(e);
      end
    end
    if (!any_invalid) begin
      for (int unsigned e = 0; e < ENTRIES; e++) begin
        if (age[e] == IDX_W'(ENTRIES - 1)) alloc_idx = IDX_W'(e);
      end
    end
    write_idx = upd_match ? match_idx : alloc_idx;

    lk_hit_any = 1'b0;
    lk_idx     = '0;
    for (int unsigned s = 0; s < FETCH_W; s++) begin
      if (hit_v[s] && !lk_hit_any) begin
        lk_hit_any = 1'b1;
        lk_idx     = slot_idx[s];
      end
    end
    // An update owns the touch; lookup touches only when fetch advances.
    touch_en  = bus.update_valid || (!bus.stall && lk_hit_any);
    touch_idx = bus.update_valid ? write_idx : lk_idx;
  end

  // Table state: update write, occupancy count and LRU age permutation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned e = 0; e < ENTRIES; e++) begin
        valid[e] <= 1'b0;
        tag[e]   <= '0;
        tgt[e]   <= '0;
        ctr[e]   <= '0;
        age[e]   <= IDX_W'(e);
      end
      occ <= '0;
    end else begin
      if (bus.update_valid) begin
        if (upd_match) begin
          if (bus.update_taken) begin
            if (ctr[write_idx] != '1) ctr[write_idx] <= ctr[write_idx] + CTR_W'(1);
            tgt[write_idx] <= bus.update_target;
          end else if (ctr[write_idx] != '0) begin
            ctr[write_idx] <= ctr[write_idx] - CTR_W'(1);
          end
        end else begin
          valid[write_idx] <= 1'b1;
          tag[write_idx]   <= bus.update_addr;
          tgt[write_idx]   <= bus.update_target;
          ctr[write_idx]   <= bus.update_taken ? CTR_WT : CTR_WNT;
          if (any_invalid) occ <= occ + OCC_W'(1);
        end
      end
      if (touch_en) begin
        for (int unsigned e = 0; e < ENTRIES; e++) begin
          if (IDX_W'(e) == touch_idx) begin
            age[e] <= '0;
          end else if (age[e] < age[touch_idx]) begin
            age[e] <= age[e] + IDX_W'(1);
          end
        end
      end
    end
  end

  assign bus.hit        = hit_v;
  assign bus.taken      = taken_v;
  assign bus.target     = target_v;
  assign bus.slot_valid = slot_valid_v;
  assign bus.next_pc    = next_pc_v;
  assign bus.occupancy  = occ;
endmodule

// File: tb/tb_btb_predictor_n.sv
// Self-checking bench for btb_predictor_n: directed scenarios followed by
// randomized traffic, all compared against a recency-list reference model.
module tb_btb_predictor_n;
  localparam int AW   = 16;
  localparam int NE   = 4;
  localparam int FW   = 2;
  localparam int IB   = 2;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  btb_predictor_n_if #(.ADDR_W(AW), .ENTRIES(NE), .FETCH_W(FW)) bus ();

  btb_predictor_n #(
    .ADDR_W(AW), .ENTRIES(NE), .FETCH_W(FW), .INSTR_BYTES(IB), .CTR_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: entry contents plus a recency list (front = most recent).
  bit m_valid [NE];
  int m_tag   [NE];
  int m_tgt   [NE];
  int m_ctr   [NE];
  int m_order [$];

  logic [FW-1:0]    e_hit, e_taken, e_sv;
  logic [FW*AW-1:0] e_target;
  logic [AW-1:0]    e_npc;
  int               e_first_entry;

  task automatic model_reset();
    m_order = {};
    for (int e = 0; e < NE; e++) begin
      m_valid[e] = 0; m_tag[e] = 0; m_tgt[e] = 0; m_ctr[e] = 0;
      m_order.push_back(e);
    end
  endtask

  task automatic model_eval();
    int a;
    bit redirected;
    e_hit = '0; e_taken = '0; e_target = '0; e_first_entry = -1;
    for (int s = 0; s < FW; s++) begin
      a = (int'(bus.lookup_pc) + s * IB) % (1 << AW);
      for (int e = 0; e < NE; e++) begin
        if (m_valid[e] && m_tag[e] == a) begin
          e_hit[s] = 1'b1;
          e_taken[s] = (m_ctr[e] >= (1 << (CW - 1)));
          e_target[s*AW +: AW] = AW'(m_tgt[e]);
          if (e_first_entry < 0) e_first_entry = e;
        end
      end
    end
    redirected = 0;
    e_sv  = '1;
    e_npc = AW'((int'(bus.lookup_pc) + FW * IB) % (1 << AW));
    for (int s = 0; s < FW; s++) begin
      if (redirected) e_sv[s] = 1'b0;
      else if (e_taken[s]) begin
        redirected = 1;
        e_npc = e_target[s*AW +: AW];
      end
    end
  endtask

  task automatic model_touch(input int e);
    int pos;
    pos = -1;
    for (int i = 0; i < m_order.size(); i++) if (m_order[i] == e) pos = i;
    if (pos >= 0) m_order.delete(pos);
    m_order.push_front(e);
  endtask

  task automatic model_commit();
    int m, w;
    if (rst) return;
    model_eval();
    if (bus.update_valid) begin
      m = -1;
      for (int e = 0; e < NE; e++)
        if (m_valid[e] && m_tag[e] == int'(bus.update_addr)) m = e;
      if (m >= 0) begin
        w = m;
        if (bus.update_taken) begin
          m_ctr[w] = (m_ctr[w] == CMAX) ? CMAX : m_ctr[w] + 1;
          m_tgt[w] = int'(bus.update_target);
        end else begin
          m_ctr[w] = (m_ctr[w] == 0) ? 0 : m_ctr[w] - 1;
        end
      end else begin
        w = -1;
        for (int e = 0; e < NE; e++) if (!m_valid[e] && w < 0) w = e;
        if (w < 0) w = m_order[NE-1];
        m_valid[w] = 1;
        m_tag[w]   = int'(bus.update_addr);
        m_tgt[w]   = int'(bus.update_target);
        m_ctr[w]   = bus.update_taken ? (1 << (CW - 1)) : (1 << (CW - 1)) - 1;
      end
      model_touch(w);
    end else if (!bus.stall && e_first_entry >= 0) begin
      model_touch(e_first_entry);
    end
  endtask

  function automatic int model_occ();
    int n;
    n = 0;
    for (int e = 0; e < NE; e++) if (m_valid[e]) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    model_eval();
    chk({tag, ".hit"},        64'(bus.hit),        64'(e_hit));
    chk({tag, ".taken"},      64'(bus.taken),      64'(e_taken));
    chk({tag, ".target"},     64'(bus.target),     64'(e_target));
    chk({tag, ".slot_valid"}, 64'(bus.slot_valid), 64'(e_sv));
    chk({tag, ".next_pc"},    64'(bus.next_pc),    64'(e_npc));
    chk({tag, ".occupancy"},  64'(bus.occupancy),  64'(model_occ()));
  endtask

  task automatic drive(input logic [AW-1:0] pc, input logic st, input logic uv,
                       input logic [AW-1:0] ua, input logic ut, input logic [AW-1:0] utg);
    bus.lookup_pc = pc; bus.stall = st; bus.update_valid = uv;
    bus.update_addr = ua; bus.update_taken = ut; bus.update_target = utg;
  endtask

  task automatic sample(input string tag);
    #1;
    check_all(tag);
  endtask

  task automatic commit();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag);
    sample(tag);
    commit();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    drive(16'h0010, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    sample("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic upd(input logic [AW-1:0] a, input logic t, input logic [AW-1:0] tg,
                     input string tag);
    drive(16'h0000, 1'b1, 1'b1, a, t, tg);
    step(tag);
  endtask

  initial begin
    drive(16'h0010, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    model_reset();
    @(negedge clk);
    do_reset();

    // Empty table
    drive(16'h0010, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    sample("t1");
    chk("t1.hit_c", 64'(bus.hit), 64'h0);
    chk("t1.sv_c", 64'(bus.slot_valid), 64'h3);
    chk("t1.npc_c", 64'(bus.next_pc), 64'h0014);
    chk("t1.occ_c", 64'(bus.occupancy), 64'h0);
    commit();

    // Slot 1 taken
    upd(16'h0012, 1'b1, 16'h0040, "t2.u");
    drive(16'h0010, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    sample("t2");
    chk("t2.hit_c", 64'(bus.hit), 64'h2);
    chk("t2.taken_c", 64'(bus.taken), 64'h2);
    chk("t2.npc_c", 64'(bus.next_pc), 64'h0040);
    chk("t2.sv_c", 64'(bus.slot_valid), 64'h3);
    chk("t2.occ_c", 64'(bus.occupancy), 64'h1);
    commit();

    // Slot 0 taken wins and squashes slot 1
    upd(16'h0010, 1'b1, 16'h0080, "t3.u");
    drive(16'h0010, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    sample("t3a");
    chk("t3a.taken_c", 64'(bus.taken), 64'h3);
    chk("t3a.npc_c", 64'(bus.next_pc), 64'h0080);
    chk("t3a.sv_c", 64'(bus.slot_valid), 64'h1);
    commit();
    upd(16'h0010, 1'b0, 16'h0BAD, "t3.nt1");
    upd(16'h0010, 1'b0, 16'h0BAD, "t3.nt2");
    drive(16'h0010, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    sample("t3b");
    chk("t3b.taken_c", 64'(bus.taken), 64'h2);
    chk("t3b.npc_c", 64'(bus.next_pc), 64'h0040);
    chk("t3b.tgt0_c", 64'(bus.target[15:0]), 64'h0080);
    commit();

    // Counter saturation at all-ones
    for (int i = 0; i < 3; i++) upd(16'h0012, 1'b1, 16'h0040, "t4.t");
    upd(16'h0012, 1'b0, 16'h0000, "t4.nt1");
    drive(16'h0010, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    sample("t4a");
    chk("t4a.taken_c", 64'(bus.taken), 64'h2);
    commit();
    upd(16'h0012, 1'b0, 16'h0000, "t4.nt2");
    drive(16'h0010, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    sample("t4b");
    chk("t4b.taken_c", 64'(bus.taken), 64'h0);
    chk("t4b.npc_c", 64'(bus.next_pc), 64'h0014);
    commit();

    // LRU eviction, with and without a stalled lookup touch
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      upd(16'h0100, 1'b1, 16'h1000, "t5.f");
      upd(16'h0200, 1'b1, 16'h2000, "t5.f");
      upd(16'h0300, 1'b1, 16'h3000, "t5.f");
      upd(16'h0400, 1'b1, 16'h4000, "t5.f");
      drive(16'h0100, pass[0], 1'b0, 16'h0000, 1'b0, 16'h0000);
      step("t5.look");
      upd(16'h0500, 1'b1, 16'h5000, "t5.ev");
      drive(16'h0200, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
      sample("t5a");
      chk("t5a.hit_c", 64'(bus.hit[0]), pass == 0 ? 64'h0 : 64'h1);
      chk("t5a.occ_c", 64'(bus.occupancy), 64'h4);
      commit();
      drive(16'h0100, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
      sample("t5b");
      chk("t5b.hit_c", 64'(bus.hit[0]), pass == 0 ? 64'h1 : 64'h0);
      commit();
    end

    // Slot address wraps past the top of the address space
    upd(16'h0000, 1'b1, 16'h0100, "t6.u");
    drive(16'hFFFE, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    sample("t6");
    chk("t6.hit_c", 64'(bus.hit), 64'h2);
    chk("t6.npc_c", 64'(bus.next_pc), 64'h0100);
    commit();

    // Asynchronous reset in the middle of an update cycle
    drive(16'h0010, 1'b0, 1'b1, 16'h0300, 1'b1, 16'h1234);
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    chk("t6r.hit_c", 64'(bus.hit), 64'h0);
    chk("t6r.taken_c", 64'(bus.taken), 64'h0);
    chk("t6r.target_c", 64'(bus.target), 64'h0);
    chk("t6r.sv_c", 64'(bus.slot_valid), 64'h3);
    chk("t6r.npc_c", 64'(bus.next_pc), 64'h0014);
    chk("t6r.occ_c", 64'(bus.occupancy), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(16'h0300, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    sample("t6post");
    chk("t6post.occ_c", 64'(bus.occupancy), 64'h0);
    commit();

    // Randomized traffic over a small address pool to force hits and evictions
    do_reset();
    for (int i = 0; i < 800; i++) begin
      logic [AW-1:0] pc, ua;
      pc = ($urandom_range(0, 15) == 0) ? 16'hFFFE : AW'(16'h0100 + 2 * $urandom_range(0, 11));
      ua = ($urandom_range(0, 15) == 0) ? 16'h0000 : AW'(16'h0100 + 2 * $urandom_range(0, 11));
      drive(pc, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1), ua,
            ($urandom_range(0, 2) != 0), AW'($urandom_range(0, 32767) * 2));
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/btb_predictor_n.md
Name: btb_predictor_n

Overview:
Parametrised branch target buffer for an N-wide superscalar fetch stage. It replaces the fixed 4-entry, 2-slot predictor with a configurable table and FETCH_W lookup slots. Each entry holds a CTR_W-bit saturating counter and true-LRU replacement, with a real update port driven from branch resolution. It sits beside the fetch PC register, computes the next fetch PC and per-slot validity combinationally, and commits table updates on the clock edge.

Parameters:
ADDR_W, 16, PC/target width in bits
ENTRIES, 8, table entries (power of 2, >=2)
FETCH_W, 2, instructions looked up per cycle (>=1)
INSTR_BYTES, 2, byte stride between consecutive slots
CTR_W, 2, saturating counter width (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset; clears the table
stall  in  1  fetch stalled; suppresses LRU touches from lookups
lookup_pc  in  ADDR_W  PC of slot 0
hit  out  FETCH_W  bit i: slot i address matches a valid entry
taken  out  FETCH_W  bit i: hit[i] and counter MSB set
target  out  FETCH_W*ADDR_W  slot i target at bits [i*ADDR_W +: ADDR_W]; 0 if no hit
slot_valid  out  FETCH_W  bit i: slot i is on the predicted path
next_pc  out  ADDR_W  predicted next fetch PC
update_valid  in  1  resolved branch update this cycle
update_addr  in  ADDR_W  resolved branch PC
update_taken  in  1  resolved direction
update_target  in  ADDR_W  resolved target
occupancy  out  clog2(ENTRIES)+1  count of valid entries (registered)

Behaviour:
- Entry state: valid, tag (full ADDR_W address), target, ctr[CTR_W-1:0], age[clog2(ENTRIES)-1:0].
- Reset (async, rst=1): all valid=0, ctr=0, target=0, tag=0, age[i]=i, occupancy=0. With an empty table: hit=0, taken=0, target=0, slot_valid=all 1, next_pc=lookup_pc+FETCH_W*INSTR_BYTES.
- Lookup is combinational, zero latency. Slot i address is lookup_pc + i*INSTR_BYTES, wrapping mod 2^ADDR_W. Only valid entries can match.
- Let k be the lowest i with taken[i]=1:
  - If k exists: next_pc = target[k], slot_valid[j]=1 for j<=k and 0 for j>k.
  - If no k exists: next_pc = lookup_pc + FETCH_W*INSTR_BYTES, with wrap.
- Lookups always read pre-edge table state. A same-cycle update is not visible until the next cycle.
- Update is sequential, at the posedge with update_valid=1:
  - Match (valid and tag==update_addr):
    - ctr saturating +1 if taken, -1 if not. It holds at all-ones and at 0.
    - target is overwritten only when update_taken=1.
  - Miss: allocate the lowest-index invalid entry; if none is invalid, allocate the entry with age==ENTRIES-1 (the LRU).
    - Write tag and target.
    - ctr = weakly taken (MSB=1, rest 0) if taken, else weakly not-taken (MSB=0, rest 1).
    - valid=1. occupancy increments only when an invalid entry was filled.
  - Duplicate tags never exist.
- LRU touch of entry e:
  - Every entry with age < age[e] increments; age[e] becomes 0.
  - Ages always form a permutation of 0..ENTRIES-1.
- Touch sources:
  - An update touches the written entry.
  - A lookup with stall=0 and update_valid=0 touches the entry hit by the lowest-index hitting slot.
  - When update_valid=1, lookup touches are dropped, so there is exactly one touch per cycle at most.
- stall affects only LRU touching. Lookup outputs and updates are unaffected.
- rst asserted mid-cycle or mid-update: the table clears immediately and the update is lost.
- ENTRIES=2 and FETCH_W=1 are legal. With FETCH_W=1, slot_valid is constantly 1.

Test Plan (ENTRIES=4, FETCH_W=2, ADDR_W=16, INSTR_BYTES=2, CTR_W=2):
1. Reset, then lookup_pc=0x0010 -> hit=00, slot_valid=11, next_pc=0x0014, occupancy=0.
2. Update 0x0012 taken, target 0x0040; next cycle lookup_pc=0x0010 -> hit=10, taken=10, next_pc=0x0040, slot_valid=11, occupancy=1.
3. Update 0x0010 taken, target 0x0080, alongside entry from 2; lookup 0x0010 -> taken=11, next_pc=0x0080, slot_valid=01. Then 2x update 0x0010 not-taken -> ctr 10->01->00; lookup gives taken=10, next_pc=0x0040.
4. Counter saturation: 3x update 0x0012 taken -> ctr 11. One not-taken -> ctr 10, still taken.
5. LRU eviction:
   - Fill 0x0100, 0x0200, 0x0300, 0x0400 in order.
   - Lookup 0x0100 with stall=0.
   - Update 0x0500 -> evicts 0x0200; lookup 0x0200 misses, 0x0100 still hits, occupancy=4.
   - Repeat with stall=1 on the lookup -> 0x0100 is evicted.
6. Wrap-around: entry at 0x0000 taken, target 0x0100; lookup_pc=0xFFFE -> slot 1 address 0x0000 hits, next_pc=0x0100. Assert rst mid-update -> all outputs return to reset values that same cycle.
